// File: rtl/basic_hash_func_pkg.sv
// Shared constants for the bridge FIB: MAC key width, FIB table size and
// the ceil(log2) helper used to size table addresses and hash outputs.
package basic_hash_func_pkg;

    // Smallest r with 2**r >= n; returns 0 for n <= 1.
    function automatic int clog2(input int n);
        int r;
        longint v;
        r = 0;
        v = 1;
        while (v < longint'(n)) begin
            v = v * 2;
            r = r + 1;
        end
        return r;
    endfunction

    localparam int MAC_W       = 48;
    localparam int FIB_ENTRIES = 256;
    localparam int FIB_ASZ     = clog2(FIB_ENTRIES);

endpackage

// File: rtl/basic_hash_func.sv
// XOR-fold hash of a wide key onto a table index in [0, hf_entries).
// Combinational by default; reg_out=1 adds a single output register.
module basic_hash_func
    import basic_hash_func_pkg::*;
#(
    parameter int input_sz   = 48,
    parameter int hf_entries = 256,
    parameter bit reg_out    = 1'b0,
    localparam int hsz       = (clog2(hf_entries) < 1) ? 1 : clog2(hf_entries)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [input_sz-1:0] hf_in,
    output logic [hsz-1:0]      hf_out
);

    // Key is padded with zeros up to a whole number of hsz-bit chunks.
    localparam int NCH  = (input_sz + hsz - 1) / hsz;
    localparam int PADW = NCH * hsz;
    // Table size held one bit wider than the index so powers of two fit.
    localparam logic [hsz:0] ENT = (hsz + 1)'(hf_entries);

    logic [PADW-1:0] key_pad;
    logic [hsz-1:0]  fold_d;
    logic [hsz-1:0]  idx_d;

    // Zero-extend the key; the top chunk gets zeros in its upper bits.
    always_comb begin
        key_pad                = '0;
        key_pad[input_sz-1:0]  = hf_in;
    end

    // XOR all chunks together, chunk k taken from bits [k*hsz +: hsz].
    always_comb begin
        fold_d = '0;
        for (int k = 0; k < NCH; k++) begin
            fold_d = fold_d ^ key_pad[k*hsz +: hsz];
        end
    end

    // Range reduction: since 2**hsz < 2*hf_entries, the fold is below
    // 2*hf_entries and one conditional subtract gives the exact modulo.
    // For power-of-two tables the compare is never true and folds away.
    always_comb begin
        if ({1'b0, fold_d} >= ENT) begin
            idx_d = fold_d - ENT[hsz-1:0];
        end else begin
            idx_d = fold_d;
        end
    end

    if (reg_out) begin : g_reg
        logic [hsz-1:0] hf_out_q;

        // Output register: reset forces index 0, dropping any pending value.
        always_ff @(posedge clk) begin
            if (reset) begin
                hf_out_q <= '0;
            end else begin
                hf_out_q <= idx_d;
            end
        end

        assign hf_out = hf_out_q;
    end else begin : g_comb
        // Clock and reset are kept on the port list but have no function here.
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ reset;

        assign hf_out = idx_d;
    end

endmodule

// File: tb/tb_basic_hash_func.sv
// Directed and random checks of basic_hash_func across several configurations:
// defaults (48/256 comb), non-power-of-two (48/100), padded key (10/16),
// single-entry table (8/1) and registered output (48/256, reg_out=1).
module tb_basic_hash_func;

    logic        clk;
    logic        reset;
    logic [47:0] key48;
    logic [9:0]  key10;
    logic [7:0]  key8;
    logic [47:0] key_reg;

    logic [7:0] out_def;
    logic [6:0] out_np;
    logic [3:0] out_pad;
    logic [0:0] out_one;
    logic [7:0] out_reg;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } item_t;

    item_t sb[$];

    basic_hash_func #(.input_sz(48), .hf_entries(256), .reg_out(1'b0)) u_def (
        .clk(clk), .reset(reset), .hf_in(key48), .hf_out(out_def));
    basic_hash_func #(.input_sz(48), .hf_entries(100), .reg_out(1'b0)) u_np (
        .clk(clk), .reset(reset), .hf_in(key48), .hf_out(out_np));
    basic_hash_func #(.input_sz(10), .hf_entries(16), .reg_out(1'b0)) u_pad (
        .clk(clk), .reset(reset), .hf_in(key10), .hf_out(out_pad));
    basic_hash_func #(.input_sz(8), .hf_entries(1), .reg_out(1'b0)) u_one (
        .clk(clk), .reset(reset), .hf_in(key8), .hf_out(out_one));
    basic_hash_func #(.input_sz(48), .hf_entries(256), .reg_out(1'b1)) u_reg (
        .clk(clk), .reset(reset), .hf_in(key_reg), .hf_out(out_reg));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: bit i of the key lands in fold bit (i mod hsz), then mod entries.
    function automatic logic [31:0] model(input logic [63:0] key, input int w, input int ent);
        int hs;
        int fold;
        hs = 0;
        while ((1 << hs) < ent) hs++;
        if (hs == 0) hs = 1;
        fold = 0;
        for (int i = 0; i < w; i++) begin
            if (key[i]) fold = fold ^ (1 << (i % hs));
        end
        return 32'(fold % ent);
    endfunction

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            0:       return 32'(out_def);
            1:       return 32'(out_np);
            2:       return 32'(out_pad);
            3:       return 32'(out_one);
            default: return 32'(out_reg);
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input logic [31:0] exp);
        item_t it;
        it.tag = tag;
        it.sel = sel;
        it.exp = exp;
        sb.push_back(it);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare every pending expectation against the output it names.
    task automatic drain();
        item_t it;
        while (sb.size() > 0) begin
            it = sb.pop_front();
            check(it.tag, observe(it.sel), it.exp);
        end
    endtask

    // Apply one key to the comb instances and queue model results for each.
    task automatic drive_comb(input string tag, input logic [47:0] k);
        key48 = k;
        key10 = k[9:0];
        key8  = k[7:0];
        push({tag, "_def"}, 0, model(64'(k), 48, 256));
        push({tag, "_np"},  1, model(64'(k), 48, 100));
        push({tag, "_pad"}, 2, model(64'(k[9:0]), 10, 16));
        push({tag, "_one"}, 3, model(64'(k[7:0]), 8, 1));
    endtask

    logic [47:0] rk;
    logic [47:0] saved_key;
    logic [7:0]  saved_def;
    logic [6:0]  saved_np;

    initial begin
        reset   = 1'b1;
        key48   = '0;
        key10   = '0;
        key8    = '0;
        key_reg = 48'h1234_5678_9ABC;

        // Directed vectors with hand-derived expectations
        key48 = 48'h0; #1;
        check("def_zero", 32'(out_def), 32'h00);
        key48 = 48'h0000_0000_00A5; #1;
        check("def_a5", 32'(out_def), 32'hA5);
        key48 = 48'h0102_0304_0506; #1;
        check("def_bytes", 32'(out_def), 32'h07);
        key48 = 48'hFFFF_FFFF_FFFF; #1;
        check("def_ones", 32'(out_def), 32'h00);
        key48 = 48'h7F; #1;
        check("np_127", 32'(out_np), 32'd27);
        key48 = 48'h3F; #1;
        check("np_63", 32'(out_np), 32'd63);
        key48 = 48'h64; #1;
        check("np_100", 32'(out_np), 32'd0);
        key48 = 48'h63; #1;
        check("np_99", 32'(out_np), 32'd99);
        key48 = 48'h0000_0000_3F80; #1;
        check("np_chunk1", 32'(out_np), 32'd27);
        key10 = 10'h3FF; #1;
        check("pad_3ff", 32'(out_pad), 32'h3);
        key10 = 10'h200; #1;
        check("pad_top", 32'(out_pad), 32'h2);
        key8 = 8'hFF; #1;
        check("one_ff", 32'(out_one), 32'h0);

        // Registered output: reset state, latency, reset override
        @(posedge clk); #1;
        check("reg_reset", 32'(out_reg), 32'h00);
        reset   = 1'b0;
        key_reg = 48'hA5; #1;
        check("reg_no_bypass", 32'(out_reg), 32'h00);
        @(posedge clk); #1;
        check("reg_a5", 32'(out_reg), 32'hA5);
        reset = 1'b1;
        @(posedge clk); #1;
        check("reg_reset_mid", 32'(out_reg), 32'h00);
        reset = 1'b0;
        @(posedge clk); #1;
        check("reg_after_rel", 32'(out_reg), 32'hA5);

        // Pipelined stream: expectation queued at drive, compared after the edge
        for (int i = 0; i < 20; i++) begin
            rk = {$urandom(), $urandom()};
            key_reg = rk;
            push($sformatf("reg_stream%0d", i), 4, model(64'(rk), 48, 256));
            @(posedge clk); #1;
            drain();
        end

        // Random sweep on the comb instances
        for (int i = 0; i < 10000; i++) begin
            rk = {$urandom(), $urandom()};
            drive_comb("rnd", rk);
            #1;
            n_cmp++;
            assert (out_np < 7'd100) else begin
                n_err++;
                $error("FAIL np_range: observed %0d expected below 100", out_np);
            end
            drain();
        end

        // Determinism: same key after unrelated traffic gives the same index
        saved_key = 48'hDEAD_BEEF_0042;
        key48 = saved_key; #1;
        saved_def = out_def;
        saved_np  = out_np;
        for (int i = 0; i < 5; i++) begin
            key48 = {$urandom(), $urandom()}; #1;
        end
        key48 = saved_key; #1;
        check("det_def", 32'(out_def), 32'(saved_def));
        check("det_np", 32'(out_np), 32'(saved_np));
        drive_comb("det_model", saved_key); #1;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
